// File: rtl/raw_readout_pkg.sv
// Shared constants and FSM state type for the raw hit readout.
// Imported by raw_trig_fifo and raw_hits_readout.
package raw_readout_pkg;

  localparam int RAW_W           = 672;
  localparam int FRAME_W         = 16;
  localparam int FRAMES_PER_WORD = 42;
  localparam int ADDR_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ADDR,
    ST_LOAD,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/raw_trig_fifo.sv
// Small FIFO of trigger window start addresses.
// A push while full is dropped; push and pop in one cycle both happen.
module raw_trig_fifo
  import raw_readout_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE  = 1;
  localparam logic [AW:0]   C_ONE  = 1;
  localparam logic [AW:0]   C_FULL = DEPTH[AW:0];

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == C_FULL);
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  // storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + P_ONE;
      end
      if (do_pop) rp <= rp + P_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + C_ONE;
        2'b01:   cnt <= cnt - C_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/raw_hits_readout.sv
// Raw hit readout: queues L1A windows and streams 672-bit words as 16-bit frames.
// Optional header frame per event when RAW_READOUT_HEADER_EN is defined.
module raw_hits_readout
  import raw_readout_pkg::*;
#(
  parameter int TRIG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1a,
  input  logic [7:0]        l1a_delay,
  input  logic [7:0]        wblock,
  input  logic [ADDR_W-1:0] adw,
  output logic [ADDR_W-1:0] adr,
  output logic [ADDR_W-1:0] adb,
  input  logic [RAW_W-1:0]  dr,
  output logic [FRAME_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              trig_overflow,
  output logic              busy
);

  localparam logic [5:0] LAST_FRAME = 6'(FRAMES_PER_WORD - 1);

  state_t            state;
  state_t            state_nxt;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] fifo_head;
  logic [ADDR_W-1:0] start_now;
  logic [ADDR_W-1:0] cur;
  logic [RAW_W-1:0]  sr;
  logic [5:0]        fcnt;
  logic [8:0]        wcnt;
  logic              word_done;
  logic              evt_done;

  assign start_now = adw - l1a_delay;
  assign word_done = (fcnt == LAST_FRAME);
  assign evt_done  = word_done && (wcnt == {1'b0, wblock});

  raw_trig_fifo #(
    .DEPTH (TRIG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (l1a),
    .pop   (pop),
    .din   (start_now),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state, fifo pop and frame outputs
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    dout       = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
`ifdef RAW_READOUT_HEADER_EN
          state_nxt = ST_HEADER;
`else
          state_nxt = ST_ADDR;
`endif
        end
      end
`ifdef RAW_READOUT_HEADER_EN
      ST_HEADER: begin
        dout       = {cur, wblock};
        dout_valid = 1'b1;
        if (dout_ready) state_nxt = ST_ADDR;
      end
`endif
      ST_ADDR: state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        dout       = sr[FRAME_W-1:0];
        dout_valid = 1'b1;
        dout_last  = evt_done;
        if (dout_ready && word_done)
          state_nxt = evt_done ? ST_IDLE : ST_ADDR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // datapath: addresses, shift register, counters, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr           <= '0;
      adb           <= '0;
      cur           <= '0;
      sr            <= '0;
      fcnt          <= '0;
      wcnt          <= '0;
      trig_overflow <= 1'b0;
      busy          <= 1'b0;
    end else begin
      trig_overflow <= l1a && fifo_full;
      busy          <= (state != ST_IDLE) || !fifo_empty;
      if (state != ST_IDLE) adb <= cur;
      else if (!fifo_empty) adb <= fifo_head;
      else                  adb <= start_now;
      if (pop) begin
        adr  <= fifo_head;
        cur  <= fifo_head;
        wcnt <= '0;
      end
      if (state == ST_LOAD) begin
        sr   <= dr;
        fcnt <= '0;
      end
      if (state == ST_SHIFT && dout_ready) begin
        sr <= sr >> FRAME_W;
        if (word_done) begin
          if (!evt_done) begin
            adr  <= adr + 8'd1;
            wcnt <= wcnt + 9'd1;
          end
        end else begin
          fcnt <= fcnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_raw_hits_readout.sv
// Scoreboard bench for raw_hits_readout.
// Memory word at address a holds frame i = {a, i}.
module tb_raw_hits_readout;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } fr_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         l1a = 1'b0;
  logic [7:0]   l1a_delay = '0;
  logic [7:0]   wblock = '0;
  logic [7:0]   adw = '0;
  logic [7:0]   adr;
  logic [7:0]   adb;
  logic [671:0] dr = '0;
  logic [15:0]  dout;
  logic         dout_valid;
  logic         rdy = 1'b1;
  logic         dout_last;
  logic         trig_overflow;
  logic         busy;

  fr_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  ovf_cnt = 0;
  bit  throttle = 1'b0;

  raw_hits_readout #(
    .TRIG_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .l1a           (l1a),
    .l1a_delay     (l1a_delay),
    .wblock        (wblock),
    .adw           (adw),
    .adr           (adr),
    .adb           (adb),
    .dr            (dr),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (rdy),
    .dout_last     (dout_last),
    .trig_overflow (trig_overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [671:0] word_of(logic [7:0] a);
    logic [671:0] w;
    w = '0;
    for (int i = 0; i < 42; i++) w[16*i +: 16] = {a, 8'(i)};
    return w;
  endfunction

  always @(posedge clk) dr <= word_of(adr);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // monitor: every accepted frame is compared with the scoreboard head
  always @(negedge clk) begin
    if (rst_n && dout_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", {15'd0, dout_last, dout}, 32'hFFFF_FFFF);
      end else begin
        fr_t e;
        e = exp_q.pop_front();
        chk("frame", {15'd0, dout_last, dout}, {15'd0, e.last, e.d});
      end
    end
    if (trig_overflow) ovf_cnt++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_event(logic [7:0] start, logic [7:0] wb);
    fr_t f;
`ifdef RAW_READOUT_HEADER_EN
    f.d = {start, wb};
    f.last = 1'b0;
    exp_q.push_back(f);
`endif
    for (int w = 0; w <= int'(wb); w++) begin
      for (int i = 0; i < 42; i++) begin
        f.d = {8'(int'(start) + w), 8'(i)};
        f.last = (w == int'(wb)) && (i == 41);
        exp_q.push_back(f);
      end
    end
  endtask

  // drive one l1a cycle from a negedge; l1a stays high for the caller
  task automatic fire(logic [7:0] a, bit expect_it);
    adw = a;
    l1a = 1'b1;
    if (expect_it) push_event(a - l1a_delay, wblock);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int first;
    repeat (3) @(negedge clk);
    chk("rst_adr", {24'd0, adr}, 32'd0);
    chk("rst_adb", {24'd0, adb}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_last", {31'd0, dout_last}, 32'd0);
    chk("rst_ovf", {31'd0, trig_overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single word, first-frame latency
    l1a_delay = 8'd20;
    wblock = 8'd0;
    fire(8'd50, 1'b1);
    l1a = 1'b0;
`ifdef RAW_READOUT_HEADER_EN
    first = 1;
`else
    first = 3;
`endif
    repeat (first - 1) @(negedge clk);
    chk("valid_before_first", {31'd0, dout_valid}, 32'd0);
    @(negedge clk);
    chk("valid_first", {31'd0, dout_valid}, 32'd1);
    drain();

    // wrap below zero, adb hold and tracking
    l1a_delay = 8'd10;
    wblock = 8'd2;
    fire(8'd5, 1'b1);
    l1a = 1'b0;
    repeat (10) @(negedge clk);
    chk("adb_event", {24'd0, adb}, 32'd251);
    chk("busy_event", {31'd0, busy}, 32'd1);
    drain();
    adw = 8'd100;
    repeat (2) @(negedge clk);
    chk("adb_track", {24'd0, adb}, 32'd90);

    // read address wraps 255 -> 0
    l1a_delay = 8'd0;
    wblock = 8'd3;
    fire(8'd254, 1'b1);
    l1a = 1'b0;
    drain();

    // fifo fill and overflow while busy
    wblock = 8'd0;
    fire(8'd200, 1'b1);
    l1a = 1'b0;
    repeat (6) @(negedge clk);
    ovf_cnt = 0;
    fire(8'd10, 1'b1);
    fire(8'd20, 1'b1);
    fire(8'd30, 1'b1);
    fire(8'd40, 1'b1);
    fire(8'd50, 1'b0);
    l1a = 1'b0;
    drain();
    chk("overflow_pulses", 32'(ovf_cnt), 32'd1);

    // throttled stream
    wblock = 8'd1;
    throttle = 1'b1;
    fire(8'd77, 1'b1);
    l1a = 1'b0;
    drain();
    throttle = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of an event
    fire(8'd120, 1'b1);
    l1a = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_adr", {24'd0, adr}, 32'd0);
    chk("mid_rst_adb", {24'd0, adb}, 32'd0);
    chk("mid_rst_dout", {16'd0, dout}, 32'd0);
    chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("mid_rst_last", {31'd0, dout_last}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("post_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/raw_hits_readout.md
# raw_hits_readout

Readout stage downstream of the 672-bit raw hit memory. On each L1A it computes the window start address from the memory write pointer, queues it, then fetches `wblock+1` consecutive 672-bit words and serializes each into 42 16-bit frames on a valid/ready stream to the DAQ link. It also drives the memory's protected-base address `adb` so the memory's `full` flag guards unread windows.

## Interface
Parameters:
- `TRIG_DEPTH`, 4: trigger-address FIFO depth (power of 2).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `l1a` in 1: trigger pulse, one cycle per trigger.
- `l1a_delay` in 8: pipeline depth in words; start = `adw - l1a_delay` mod 256.
- `wblock` in 8: window length minus one; an event is `wblock+1` words. Quasi-static.
- `adw` in 8: current memory write address.
- `adr` out 8: memory read address (registered).
- `adb` out 8: oldest address still needed (registered).
- `dr` in 672: memory read data, valid one cycle after `adr` is sampled by memory.
- `dout` out 16: frame data.
- `dout_valid` out 1: frame valid.
- `dout_ready` in 1: downstream accepts the frame when high with `dout_valid`.
- `dout_last` out 1: last frame of an event.
- `trig_overflow` out 1: one-cycle pulse, trigger dropped.
- `busy` out 1: event in progress or FIFO non-empty.

## Operation
- `l1a` pushes `adw - l1a_delay` (8-bit wrap) into the FIFO. If the FIFO is full, no push and `trig_overflow` pulses. Push and pop in the same cycle both take effect.
- FSM states:
  - IDLE: if FIFO non-empty, pop, `adr<=start`, `cur<=start`, word count 0 -> HEADER (if enabled) else ADDR.
  - HEADER: present header frame; on accept -> ADDR.
  - ADDR: one cycle while memory registers `adr` -> LOAD.
  - LOAD: capture `dr` into 672-bit shift register, frame count 0 -> SHIFT.
  - SHIFT: `dout=sr[15:0]`, `dout_valid=1`. On accept, shift right 16.
    - After frame 41: if word count == `wblock`, `dout_last` was high on that frame -> IDLE.
    - Otherwise `adr<=adr+1` (wraps 255->0), word count +1 -> ADDR.
- Stall: `dout`, `dout_valid`, `dout_last` hold while `dout_ready` is low.
- `adb`: during an event, `cur`; in IDLE with the FIFO non-empty, the FIFO head; otherwise `adw - l1a_delay`.
- Counters: frame count 6-bit (0..41); word count 9-bit so `wblock=255` yields 256 words.
- Reset mid-event: FIFO flushed, FSM to IDLE, event truncated without `dout_last`.

## Timing
- Reset values: `adr=0`, `adb=0`, `dout=0`, `dout_valid=0`, `dout_last=0`, `trig_overflow=0`, `busy=0`, FSM IDLE.
- `l1a` sampled at edge k with FIFO empty and block idle: pop at k+1, memory samples `adr` at k+2, shift register loaded at k+3, first data frame valid after k+3.
- Per word: 42 frames plus 2 fetch cycles (ADDR, LOAD); no prefetch.
- Event throughput with `dout_ready` held high: `(wblock+1)*44` cycles, plus 1 with header.
- `busy` is registered and asserts the cycle after the push.

## Configuration
- `RAW_READOUT_HEADER_EN` defined: HEADER state emitted first per event; header `dout = {start[7:0], wblock[7:0]}`. Event is `(wblock+1)*42+1` frames; first frame valid after k+1.
- Undefined: no HEADER state; event is `(wblock+1)*42` frames.

## Structure
- Package `raw_readout_pkg`:
  - Constants `RAW_W=672`, `FRAME_W=16`, `FRAMES_PER_WORD=42`, `ADDR_W=8`.
  - FSM state enum.
- Sub-module `raw_trig_fifo`: `TRIG_DEPTH`×8-bit FIFO with full/empty flags, async active-low reset.

## Test plan
- `adw=50`, `l1a_delay=20`, `wblock=0`, memory word 30 = ramp pattern, `dout_ready=1`:
  - 42 frames, `frame[i]=dr[16i+15:16i]`, `dout_last` on frame 41.
  - First frame valid after edge k+3.
- `adw=5`, `l1a_delay=10`, `wblock=2`:
  - Reads addresses 251, 252, 253; `adb=251` during the event.
  - Then `adb` tracks `adw-10`.
- Start 254, `wblock=3`: addresses 254, 255, 0, 1 read in order.
- 5 `l1a` pulses back-to-back while busy, `TRIG_DEPTH=4`:
  - FIFO full, so one `trig_overflow` pulse.
  - The 4 queued events are read out in order.
- Random `dout_ready` throttling, `wblock=1`: output identical to the unthrottled run; no frame lost or duplicated.
- `rst_n` low mid-SHIFT: all outputs return to reset values immediately; after release with no `l1a`, no frames are output.
